// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register and op/funct field taps.
// Optional macro BRANCH_DELAY_SLOT_EN: the instruction in IF at redirect executes as a delay slot.
module if_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        pc,
    output logic [31:0]        if_id_instr,
    output logic [31:0]        if_id_pc4,
    output logic               if_id_valid,
    output logic               op0,
    output logic               op1,
    output logic               op2,
    output logic               op3,
    output logic               op4,
    output logic               op5,
    output logic               ft0,
    output logic               ft1,
    output logic               ft2,
    output logic               ft3,
    output logic               ft4,
    output logic               ft5
);

    logic [31:0] pc_plus4;
    logic [31:0] target;

    assign pc_plus4  = pc + 32'd4;
    assign target    = {redirect_pc[31:2], 2'b00};
    assign imem_addr = pc[IMEM_AW+1:2];

`ifdef BRANCH_DELAY_SLOT_EN
    logic        pend_valid;
    logic [31:0] pend_pc;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= PC_RESET;
            if_id_instr <= 32'h0;
            if_id_pc4   <= 32'h0;
            if_id_valid <= 1'b0;
            pend_valid  <= 1'b0;
            pend_pc     <= 32'h0;
        end else if (stall) begin
            // Delay slot not yet captured: park the target until the stall clears.
            if (redirect) begin
                pend_valid <= 1'b1;
                pend_pc    <= target;
            end
        end else begin
            if_id_instr <= imem_rdata;
            if_id_pc4   <= pc_plus4;
            if_id_valid <= 1'b1;
            pend_valid  <= 1'b0;
            if (redirect)        pc <= target;
            else if (pend_valid) pc <= pend_pc;
            else                 pc <= pc_plus4;
        end
    end
`else
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= PC_RESET;
            if_id_instr <= 32'h0;
            if_id_pc4   <= 32'h0;
            if_id_valid <= 1'b0;
        end else if (redirect) begin
            // Wrong-path fetch is squashed; an invalid slot always reads as the all-zero NOP.
            pc          <= target;
            if_id_instr <= 32'h0;
            if_id_pc4   <= 32'h0;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            pc          <= pc_plus4;
            if_id_instr <= imem_rdata;
            if_id_pc4   <= pc_plus4;
            if_id_valid <= 1'b1;
        end
    end
`endif

    assign op0 = if_id_instr[31];
    assign op1 = if_id_instr[30];
    assign op2 = if_id_instr[29];
    assign op3 = if_id_instr[28];
    assign op4 = if_id_instr[27];
    assign op5 = if_id_instr[26];
    assign ft0 = if_id_instr[5];
    assign ft1 = if_id_instr[4];
    assign ft2 = if_id_instr[3];
    assign ft3 = if_id_instr[2];
    assign ft4 = if_id_instr[1];
    assign ft5 = if_id_instr[0];

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: driver pushes hand-computed expectations, monitor pops after each edge.
// Expectations follow BRANCH_DELAY_SLOT_EN when that macro is defined for the build.
module tb_if_stage;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst, stall, redirect;
    logic [31:0]   redirect_pc;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata, pc, if_id_instr, if_id_pc4;
    logic          if_id_valid;
    logic          op0, op1, op2, op3, op4, op5;
    logic          ft0, ft1, ft2, ft3, ft4, ft5;

    logic [31:0] imem [0:(1<<AW)-1];
    assign imem_rdata = imem[imem_addr];

    if_stage #(.PC_RESET(32'h0), .IMEM_AW(AW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .pc(pc), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
        .op0(op0), .op1(op1), .op2(op2), .op3(op3), .op4(op4), .op5(op5),
        .ft0(ft0), .ft1(ft1), .ft2(ft2), .ft3(ft3), .ft4(ft4), .ft5(ft5)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          step;
        logic        rst, stall, redir;
        logic [31:0] rpc;
        logic [31:0] pc, instr, pc4;
        logic        valid;
    } vec_t;

    vec_t stim_q[$];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [31:0] LW  = 32'h8C22_0004;  // lw  $2, 4($1)
    localparam logic [31:0] SLT = 32'h0043_082A;  // slt $1, $2, $3

    task automatic check(input string name, input int step, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL step%0d %s: got %h expected %h", step, name, got, exp);
        end
    endtask

    task automatic add(input logic r, input logic s, input logic d, input logic [31:0] rpc,
                       input logic [31:0] epc, input logic [31:0] ei, input logic [31:0] ep4, input logic ev);
        vec_t v;
        v.step = stim_q.size();
        v.rst = r; v.stall = s; v.redir = d; v.rpc = rpc;
        v.pc = epc; v.instr = ei; v.pc4 = ep4; v.valid = ev;
        stim_q.push_back(v);
    endtask

    // Monitor: one expectation is consumed after every edge that followed a driven vector.
    initial begin
        vec_t e;
        logic [5:0] op_bits, ft_bits;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                op_bits = e.instr[31:26];
                ft_bits = e.instr[5:0];
                check("pc", e.step, pc, e.pc);
                check("imem_addr", e.step, {22'h0, imem_addr}, {22'h0, e.pc[AW+1:2]});
                check("valid", e.step, {31'h0, if_id_valid}, {31'h0, e.valid});
                check("instr", e.step, if_id_instr, e.instr);
                if (e.valid) check("pc4", e.step, if_id_pc4, e.pc4);
                check("op", e.step, {26'h0, op0, op1, op2, op3, op4, op5}, {26'h0, op_bits});
                check("ft", e.step, {26'h0, ft0, ft1, ft2, ft3, ft4, ft5}, {26'h0, ft_bits});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Driver
    initial begin
        vec_t v;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        for (int i = 0; i < (1 << AW); i++) imem[i] = i + 1;
        imem[8'h30] = LW;
        imem[8'h31] = SLT;

        //   rst  stall redir rpc             pc            instr         pc4           valid
        add(1'b1, 1'b0, 1'b0, 32'h0,          32'h0,        32'h0,        32'h0,        1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,          32'h4,        32'h1,        32'h4,        1'b1);
        add(1'b0, 1'b0, 1'b0, 32'h0,          32'h8,        32'h2,        32'h8,        1'b1);
        add(1'b0, 1'b0, 1'b0, 32'h0,          32'hC,        32'h3,        32'hC,        1'b1);
        add(1'b0, 1'b1, 1'b0, 32'h0,          32'hC,        32'h3,        32'hC,        1'b1);
        add(1'b0, 1'b1, 1'b0, 32'h0,          32'hC,        32'h3,        32'hC,        1'b1);
        add(1'b0, 1'b1, 1'b0, 32'h0,          32'hC,        32'h3,        32'hC,        1'b1);
        add(1'b0, 1'b0, 1'b0, 32'h0,          32'h10,       32'h4,        32'h10,       1'b1);
`ifdef BRANCH_DELAY_SLOT_EN
        add(1'b0, 1'b0, 1'b1, 32'h40,         32'h40,       32'h5,        32'h14,       1'b1);
        add(1'b0, 1'b0, 1'b0, 32'h0,          32'h44,       32'h11,       32'h44,       1'b1);
        add(1'b0, 1'b1, 1'b1, 32'h80,         32'h44,       32'h11,       32'h44,       1'b1);
        add(1'b0, 1'b0, 1'b0, 32'h0,          32'h80,       32'h12,       32'h48,       1'b1);
        add(1'b0, 1'b0, 1'b1, 32'h103,        32'h100,      32'h21,       32'h84,       1'b1);
        add(1'b0, 1'b0, 1'b0, 32'h0,          32'h104,      32'h41,       32'h104,      1'b1);
        add(1'b0, 1'b0, 1'b1, 32'hC0,         32'hC0,       32'h42,       32'h108,      1'b1);
`else
        add(1'b0, 1'b0, 1'b1, 32'h40,         32'h40,       32'h0,        32'h0,        1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,          32'h44,       32'h11,       32'h44,       1'b1);
        add(1'b0, 1'b1, 1'b1, 32'h80,         32'h80,       32'h0,        32'h0,        1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,          32'h84,       32'h21,       32'h84,       1'b1);
        add(1'b0, 1'b0, 1'b1, 32'h103,        32'h100,      32'h0,        32'h0,        1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,          32'h104,      32'h41,       32'h104,      1'b1);
        add(1'b0, 1'b0, 1'b1, 32'hC0,         32'hC0,       32'h0,        32'h0,        1'b0);
`endif
        add(1'b0, 1'b0, 1'b0, 32'h0,          32'hC4,       LW,           32'hC4,       1'b1);
        add(1'b0, 1'b0, 1'b0, 32'h0,          32'hC8,       SLT,          32'hC8,       1'b1);
        add(1'b0, 1'b1, 1'b0, 32'h0,          32'hC8,       SLT,          32'hC8,       1'b1);
`ifdef BRANCH_DELAY_SLOT_EN
        add(1'b0, 1'b1, 1'b1, 32'h200,        32'hC8,       SLT,          32'hC8,       1'b1);
`else
        add(1'b0, 1'b1, 1'b1, 32'h200,        32'h200,      32'h0,        32'h0,        1'b0);
`endif
        add(1'b1, 1'b1, 1'b0, 32'h0,          32'h0,        32'h0,        32'h0,        1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,          32'h4,        32'h1,        32'h4,        1'b1);
`ifdef BRANCH_DELAY_SLOT_EN
        add(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC,  32'hFFFF_FFFC, 32'h2,       32'h8,        1'b1);
`else
        add(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC,  32'hFFFF_FFFC, 32'h0,       32'h0,        1'b0);
`endif
        add(1'b0, 1'b0, 1'b0, 32'h0,          32'h0,        32'h400,      32'h0,        1'b1);
        add(1'b0, 1'b1, 1'b0, 32'h0,          32'h0,        32'h400,      32'h0,        1'b1);

        while (stim_q.size() > 0) begin
            v = stim_q.pop_front();
            @(negedge clk);
            rst = v.rst; stall = v.stall; redirect = v.redir; redirect_pc = v.rpc;
            exp_q.push_back(v);
        end
        @(negedge clk);
        rst = 1'b0; stall = 1'b1; redirect = 1'b0;
        @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
